// File: rtl/sa_ram_pkg.sv
// Shared defaults and port bundle for the 64x128 two-port RAM macro.
package sa_ram_pkg;

  localparam int unsigned RAM_DEPTH = 64;
  localparam int unsigned RAM_AW    = 6;
  localparam int unsigned RAM_DW    = 128;

  typedef struct packed {
    logic [RAM_AW-1:0] wa;
    logic              we;
    logic [RAM_DW-1:0] di;
    logic [RAM_AW-1:0] ra;
    logic              re;
  } ram_port_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sa_fifo_ctrl_rws_64x128_skid2.sv
// Two-entry register FIFO; the head register drives out_data directly.
module sa_skid2
  import sa_ram_pkg::*;
#(
  parameter int unsigned DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] d0_q, d1_q;
  logic          pop;
  logic          d0_load, d0_from_d1, d1_load;

  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = d0_q;
  assign occ       = state_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (state_q != SKID_FULL) | out_ready;

  always_comb begin
    state_d    = state_q;
    d0_load    = 1'b0;
    d0_from_d1 = 1'b0;
    d1_load    = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_valid) begin
          d0_load = 1'b1;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_valid && pop) begin
          d0_load = 1'b1;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end else if (in_valid) begin
          d1_load = 1'b1;
          state_d = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          d0_from_d1 = 1'b1;
          if (in_valid) d1_load = 1'b1;
          else          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SKID_EMPTY;
    else     state_q <= state_d;
  end

  // Data registers carry no reset so the head keeps its last value when empty.
  always_ff @(posedge clk) begin
    if (d0_from_d1)   d0_q <= d1_q;
    else if (d0_load) d0_q <= in_data;
    if (d1_load)      d1_q <= in_data;
  end

endmodule

// File: rtl/sa_fifo_ctrl_rws_64x128.sv
// Valid/ready FIFO controller around an external 64x128 two-port RAM with a 2-entry output skid.
module sa_fifo_ctrl_rws_64x128
  import sa_ram_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH,
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DW    = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic [31:0]   pwrbus_ram_pd,
  output logic [AW+1:0] count
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          inflight;
  logic          push, pop, issue;
  logic [1:0]    skid_occ;
  logic [2:0]    skid_claim;
  logic          skid_in_ready;

  assign wr_ready = (ram_cnt != RAM_FULL);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  // Skid slots already claimed by stored and in-flight words; a pop frees one this cycle.
  assign skid_claim = {1'b0, skid_occ} + {2'b00, inflight};
  assign issue      = (ram_cnt != '0) &&
                      ((skid_claim < 3'd2) || ((skid_claim == 3'd2) && pop));

  assign ram_we        = push;
  assign ram_wa        = wr_ptr;
  assign ram_di        = wr_data;
  assign ram_re        = issue;
  assign ram_ra        = rd_ptr;
  assign pwrbus_ram_pd = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      inflight <= issue;
      ram_cnt  <= ram_cnt + (AW+1)'(push) - (AW+1)'(issue);
      count    <= count + (AW+2)'(push) - (AW+2)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && inflight) assert (skid_in_ready);
  end

  sa_skid2 #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_ready  (skid_in_ready),
    .in_data   (ram_dout),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd_data),
    .occ       (skid_occ)
  );

endmodule
